// File: rtl/dsp_pkg.sv
// Shared DSP definitions: P-register geometry and serializer FSM state type.
package dsp_pkg;

  localparam int P_WIDTH = 48;
  localparam int BYTE_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/dsp_p_serializer.sv
// Serializes a DSP P-register result word into a byte stream with
// valid/ready handshakes on both sides; back-to-back words have no gap.
module dsp_p_serializer
  import dsp_pkg::*;
#(
  parameter int NBYTES    = P_WIDTH / BYTE_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clken,
  input  logic [BYTE_W*NBYTES-1:0] p_in,
  input  logic                     p_valid,
  output logic                     p_ready,
  output logic [BYTE_W-1:0]        dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  ser_state_t       state;
  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] count;
  logic             in_hs;
  logic             out_hs;

  always_comb begin
    dout_valid = (state == SEND);
    dout_last  = (state == SEND) && (count == LAST_CNT);
    p_ready    = (state == IDLE) || (dout_last && dout_ready);
    in_hs      = clken && p_valid && p_ready;
    out_hs     = clken && dout_valid && dout_ready;
    if (LSB_FIRST)
      dout = shreg[BYTE_W-1:0];
    else
      dout = shreg[W-1 -: BYTE_W];
  end

  // The last byte is shifted out as well, so an idle serializer presents zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
    end else if (clken) begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            shreg <= p_in;
            count <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (in_hs) begin
            shreg <= p_in;
            count <= '0;
          end else if (out_hs) begin
            if (LSB_FIRST)
              shreg <= shreg >> BYTE_W;
            else
              shreg <= shreg << BYTE_W;
            if (dout_last) begin
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_p_serializer.sv
// Directed bench for dsp_p_serializer: both byte orders checked every cycle
// against a word/byte-index model, plus literal byte sequences per scenario.
module tb_dsp_p_serializer;

  localparam int NB = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          clken;
  logic [47:0]   p_in;
  logic          p_valid;
  logic          dout_ready;
  logic          pr_l, dv_l, last_l;
  logic          pr_m, dv_m, last_m;
  logic [7:0]    dout_l, dout_m;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  dsp_p_serializer #(.NBYTES(NB), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .clken(clken), .p_in(p_in), .p_valid(p_valid),
    .p_ready(pr_l), .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .dout_last(last_l)
  );

  dsp_p_serializer #(.NBYTES(NB), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .clken(clken), .p_in(p_in), .p_valid(p_valid),
    .p_ready(pr_m), .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .dout_last(last_m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the word being sent and the index of the byte on offer.
  bit          busy = 1'b0;
  logic [47:0] word = '0;
  int          idx  = 0;
  logic        exp_pr;

  always_comb exp_pr = !busy || (idx == NB - 1 && dout_ready);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy = 1'b0;
      idx  = 0;
    end else if (clken) begin
      if (!busy) begin
        if (p_valid) begin
          busy = 1'b1; word = p_in; idx = 0;
        end
      end else if (dout_ready) begin
        if (idx == NB - 1) begin
          if (p_valid) begin
            word = p_in; idx = 0;
          end else begin
            busy = 1'b0;
          end
        end else begin
          idx++;
        end
      end
    end
  end

  logic [7:0] log_l[$];
  logic [7:0] log_m[$];
  int         stamp[$];
  int         in_stamp = -1;

  always @(negedge clk) begin
    chk("dout_valid_lsb", dv_l, busy);
    chk("dout_valid_msb", dv_m, busy);
    chk("p_ready_lsb", pr_l, exp_pr);
    chk("p_ready_msb", pr_m, exp_pr);
    chk("dout_last_lsb", last_l, busy && idx == NB - 1);
    chk("dout_last_msb", last_m, busy && idx == NB - 1);
    if (busy) begin
      chk("dout_lsb", dout_l, word[8*idx +: 8]);
      chk("dout_msb", dout_m, word[8*(NB-1-idx) +: 8]);
    end
    if (!reset && clken && p_valid && pr_l) in_stamp = cyc;
    if (!reset && clken && dv_l && dout_ready) begin
      log_l.push_back(dout_l);
      log_m.push_back(dout_m);
      stamp.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_l.delete();
    log_m.delete();
    stamp.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; p_valid = 1'b0; clken = 1'b1; dout_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic check_seq(input string nm, input logic [7:0] exp [12], input int n, input bit msb);
    chk({nm, "_len"}, msb ? log_m.size() : log_l.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < log_l.size())
        chk($sformatf("%s_byte%0d", nm, i), msb ? log_m[i] : log_l[i], exp[i]);
    end
  endtask

  logic [7:0] seq_a_l [12] = '{8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A,
                               8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] seq_a_m [12] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] seq_b_l [12] = '{8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  localparam logic [47:0] WA = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] WB = 48'h112233445566;

  initial begin
    reset = 1'b1; clken = 1'b1; p_valid = 1'b0; dout_ready = 1'b1; p_in = '0;
    #1;
    chk("reset_dout", dout_l, 8'h00);
    chk("reset_dout_valid", dv_l, 1'b0);
    chk("reset_p_ready", pr_l, 1'b1);
    chk("reset_dout_last", last_l, 1'b0);
    do_reset();

    // Single word, continuous ready, both byte orders.
    p_in = WA; p_valid = 1'b1;
    tick();
    p_valid = 1'b0; p_in = 48'hDEADBEEFCAFE;
    repeat (8) tick();
    check_seq("w1_lsb", seq_a_l, 6, 1'b0);
    check_seq("w1_msb", seq_a_m, 6, 1'b1);
    if (stamp.size() == 6) begin
      chk("w1_latency", stamp[0], in_stamp + 1);
      for (int i = 1; i < 6; i++) chk("w1_consecutive", stamp[i], stamp[0] + i);
    end
    chk("idle_dout_zero", dout_l, 8'h00);

    // Downstream stall on byte 2.
    do_reset();
    p_in = WA; p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    tick();
    tick();
    dout_ready = 1'b0;
    repeat (3) begin
      chk("stall_dout", dout_l, 8'h0D);
      chk("stall_last", last_l, 1'b0);
      tick();
    end
    chk("stall_dout_end", dout_l, 8'h0D);
    dout_ready = 1'b1;
    repeat (6) tick();
    check_seq("stall_lsb", seq_a_l, 6, 1'b0);
    check_seq("stall_msb", seq_a_m, 6, 1'b1);

    // Back-to-back words with p_valid held high.
    do_reset();
    p_in = WA; p_valid = 1'b1;
    tick();
    p_in = WB;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_p_ready_low", pr_l, 1'b0);
      tick();
    end
    chk("b2b_p_ready_high", pr_l, 1'b1);
    chk("b2b_last_a", dout_l, 8'h0A);
    tick();
    p_valid = 1'b0;
    chk("b2b_first_b", dout_l, 8'h66);
    chk("b2b_valid_b", dv_l, 1'b1);
    repeat (7) tick();
    check_seq("b2b_lsb", seq_a_l, 12, 1'b0);
    check_seq("b2b_msb", seq_a_m, 12, 1'b1);
    if (stamp.size() == 12)
      for (int i = 1; i < 12; i++) chk("b2b_no_gap", stamp[i], stamp[0] + i);

    // Reset after three bytes discards the rest of the word.
    do_reset();
    p_in = WA; p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    repeat (3) tick();
    chk("pre_reset_dout", dout_l, 8'h0C);
    reset = 1'b1;
    #1;
    chk("mid_reset_valid", dv_l, 1'b0);
    chk("mid_reset_p_ready", pr_l, 1'b1);
    chk("mid_reset_dout", dout_l, 8'h00);
    chk("mid_reset_last", last_l, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_valid", dv_l, 1'b0);
    clear_log();
    p_in = WB; p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    repeat (7) tick();
    check_seq("after_reset_lsb", seq_b_l, 6, 1'b0);

    // Clock enable low for four cycles mid-word.
    do_reset();
    p_in = WA; p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
    tick();
    clken = 1'b0;
    repeat (4) begin
      chk("clken_hold_dout", dout_l, 8'h0E);
      chk("clken_hold_valid", dv_l, 1'b1);
      tick();
    end
    clken = 1'b1;
    repeat (6) tick();
    check_seq("clken_lsb", seq_a_l, 6, 1'b0);
    check_seq("clken_msb", seq_a_m, 6, 1'b1);
    if (stamp.size() == 6) chk("clken_gap", stamp[1], stamp[0] + 5);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dsp_p_serializer.md
DSP_P_SERIALIZER -- requirements
Module: dsp_p_serializer

Interface
REQ-001 SHALL have parameter NBYTES, default 6, number of 8-bit bytes per result word (P width = 8*NBYTES).
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = byte 0 (bits 7:0) sent first; 0 = most-significant byte sent first.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clken  input  1  clock enable; when 0, all state holds.
REQ-006 SHALL have port p_in  input  8*NBYTES  result word from the DSP P register.
REQ-007 SHALL have port p_valid  input  1  p_in is valid.
REQ-008 SHALL have port p_ready  output  1  block accepts p_in this cycle.
REQ-009 SHALL have port dout  output  8  current output byte.
REQ-010 SHALL have port dout_valid  output  1  dout is valid.
REQ-011 SHALL have port dout_ready  input  1  downstream accepts dout.
REQ-012 SHALL have port dout_last  output  1  dout is the final byte of the word.

Function
REQ-013 SHALL implement FSM states IDLE and SEND, plus a shift register of 8*NBYTES bits and a byte counter of width clog2(NBYTES).
REQ-014 Input handshake SHALL occur on a rising clk edge where clken=1, p_valid=1 and p_ready=1.
REQ-015 Output handshake SHALL occur on a rising clk edge where clken=1, dout_valid=1 and dout_ready=1.
REQ-016 p_ready SHALL be combinational: 1 in IDLE, and 1 in SEND only while an output handshake on the last byte is pending (dout_last=1 and dout_ready=1).
REQ-017 IDLE + input handshake: capture p_in into the shift register, set count=0, go to SEND. dout_valid SHALL be 1 on the next cycle (latency 1) with the first byte.
REQ-018 dout SHALL be driven directly from the shift register: bits 7:0 when LSB_FIRST=1, otherwise the top 8 bits.
REQ-019 dout_valid SHALL be 1 exactly when the state is SEND; dout_last SHALL be 1 when the state is SEND and count=NBYTES-1.
REQ-020 SEND + output handshake, not last byte: shift by 8 toward the output end (zero-fill) and increment count.
REQ-021 SEND + output handshake on the last byte with no input handshake: return to IDLE.
REQ-022 SEND + output handshake on the last byte with a simultaneous input handshake: load p_in, set count=0, stay in SEND. Back-to-back words SHALL therefore have no idle gap.
REQ-023 While dout_valid=1 and dout_ready=0, dout, dout_last and count SHALL hold stable.
REQ-024 clken=0 SHALL freeze the state, counter and shift register. Outputs stay consistent with the frozen state, and no handshake completes.
REQ-025 p_in SHALL be sampled only on an input handshake; changes at any other time SHALL have no effect.

Reset
REQ-026 reset=1 SHALL immediately force: state=IDLE, shift register=0, count=0, dout=0, dout_valid=0, dout_last=0, p_ready=1.
REQ-027 Asserting reset mid-word SHALL discard the remaining bytes; after deassertion no partial byte is emitted.

Structure
REQ-028 Shared package dsp_pkg SHALL hold P_WIDTH=48, BYTE_W=8 and the FSM state typedef (IDLE, SEND).
REQ-029 The block SHALL be a single module with no sub-module; the counter and shift register are inline.

Verification
REQ-030 LSB_FIRST=1, p_in=48'h0A0B0C0D0E0F, dout_ready=1 -> dout sequence 0F,0E,0D,0C,0B,0A on 6 consecutive cycles, dout_last only on 0A, first byte one cycle after the handshake.
REQ-031 LSB_FIRST=0, same word -> sequence 0A,0B,0C,0D,0E,0F, dout_last on 0F.
REQ-032 dout_ready held 0 for 3 cycles during byte 2 -> dout stays 0D and count unchanged; sequence resumes without loss.
REQ-033 Word A followed by word B=48'h112233445566 with p_valid held high -> p_ready pulses during A's last byte, and 66 follows 0A on the next cycle with no gap.
REQ-034 reset asserted after 3 bytes of a word -> dout_valid falls to 0 immediately, p_ready=1; the next word is sent in full from byte 0.
REQ-035 clken=0 for 4 cycles mid-word with dout_ready=1 -> no bytes advance; the sequence continues unchanged once clken=1.
